uart_crc_rx_checker: RTL and testbench
======================================

# uart_crc_rx_checker

Serial-side receiver for the CRC-8 protected UART link. It deserialises a two-byte frame from the line: a data byte, then its CRC-8 byte. It recomputes CRC-8 over the data byte and presents the data with a ready pulse and a CRC-valid flag. It sits at the far end of the link from the CRC transmitter and drives the same `rx_data_out` / `rx_ready_out` / `crc_valid_out` style outputs used by `uart_crc_top`.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per UART bit; minimum 16, must be even.
- `GAP_BITS`, 20, maximum idle time between the data byte's stop bit and the CRC byte's start bit, in bit times.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_serial`  in  1  asynchronous UART line; idles high.
- `rx_data_out`  out  8  last received data byte; held until the next frame completes.
- `rx_ready_out`  out  1  one-cycle pulse when a complete frame has been checked.
- `crc_valid_out`  out  1  1 if the received CRC matched the computed CRC; updated with `rx_ready_out` and held.
- `frame_error_out`  out  1  one-cycle pulse on a bad start/stop condition or a gap timeout.

## Operation
- Line format: 8N1, LSB first.
- Frame: byte 0 is the data byte, byte 1 is the CRC byte.
- CRC-8 definition:
  - polynomial 0x07 (x^8+x^2+x+1), init 0x00, MSB-first;
  - no reflection, no final XOR;
  - computed over the data byte only.
- `rx_serial` passes through a 2-flop synchroniser (both flops reset to 1). All decisions use the synchronised value.
- States:
  - IDLE: wait for synchronised line = 0 → START; clear bit counter; hold byte index.
  - START: count to CLKS_PER_BIT/2−1, then sample. If the line is 0 → DATA. If the line is 1 → glitch: return to IDLE, or to GAP if byte index = 1. A glitch raises no error.
  - DATA: sample every CLKS_PER_BIT cycles. Shift in 8 bits LSB first → STOP.
  - STOP: sample after CLKS_PER_BIT.
    - Stop bit = 0 → `frame_error_out` pulse, discard the frame, byte index ← 0, → IDLE.
    - Stop bit = 1, byte index 0 → latch data byte, byte index ← 1, → GAP.
    - Stop bit = 1, byte index 1 → latch CRC byte → CHECK.
  - GAP: count cycles while the line is high. Line = 0 → START. Count reaching GAP_BITS×CLKS_PER_BIT → `frame_error_out` pulse, byte index ← 0, → IDLE.
  - CHECK: 8 cycles of serial CRC, one data bit per cycle, MSB first. Then in one cycle:
    - `rx_data_out` ← data;
    - `crc_valid_out` ← (crc == received CRC);
    - `rx_ready_out` ← 1;
    - byte index ← 0;
    - → IDLE.
- Outputs from a frame with an error (error pulse, or timeout) never reach `rx_data_out` or `crc_valid_out`.
- Bit counter is 3 bits. Baud counter width is clog2(GAP_BITS×CLKS_PER_BIT).

## Timing
- Reset values:
  - `rx_data_out` = 0x00
  - `rx_ready_out` = 0
  - `crc_valid_out` = 0
  - `frame_error_out` = 0
  - state = IDLE, byte index = 0, synchroniser = 1.
- Reset asserted mid-frame: next cycle all of the above. The partial frame is lost and no pulse is emitted.
- Synchroniser latency: 2 cycles from the `rx_serial` edge to the state machine.
- Sample points: mid-bit. The start bit is sampled at CLKS_PER_BIT/2 cycles after detection; each later bit is sampled CLKS_PER_BIT cycles after the previous sample.
- Latency: let S be the cycle the CRC byte's stop bit is sampled. CHECK occupies S+1..S+8. `rx_ready_out` is high in cycle S+9 only. `rx_data_out` and `crc_valid_out` are valid from S+9.
- The next start edge can be detected no earlier than S+CLKS_PER_BIT/2+2 ≥ S+10, so no start bit is lost during CHECK.
- `frame_error_out` is high for exactly the cycle after the failing sample or the timeout.
- `rx_ready_out` and `frame_error_out` are never high in the same cycle.

## Test plan
- Send 0xAA, then 0x5F, CLKS_PER_BIT=16 → one `rx_ready_out` pulse, `rx_data_out`=0xAA, `crc_valid_out`=1, no error. Measure the pulse at exactly S+9.
- Send 0xCC, then 0x6A, back-to-back with a minimum 1-bit idle; then 0xFF, then 0xF3 → two pulses, data 0xCC then 0xFF, `crc_valid_out`=1 both times.
- Send 0xAA, then 0x5E (corrupted CRC) → pulse, `rx_data_out`=0xAA, `crc_valid_out`=0. Follow with 0x00, then 0x00 → `crc_valid_out` returns to 1.
- Drive the data byte's stop bit low → one `frame_error_out` pulse, no `rx_ready_out`. A following good frame 0xAA, 0x5F is received correctly.
- Low glitch of 3 cycles on an idle line → no outputs change, state returns to IDLE. Send data byte 0x55, then idle for more than 20 bit times → `frame_error_out` pulse at exactly 320 cycles after the stop sample, no ready pulse.
- Assert `reset` for 1 cycle during the CRC byte's data bits → all outputs 0 next cycle. The rest of the aborted frame produces no ready pulse. A subsequent 0xCC, 0x6A frame is received valid.

Source files
------------

// File: rtl/uart_crc_rx_checker.sv
`default_nettype none
// ============================================================================
// Module      : uart_crc_rx_checker
// Description : Receiver for the CRC-8 protected UART link. Deserialises a
//               two-byte 8N1 frame (data byte, then its CRC-8 byte), recomputes
//               CRC-8 (poly 0x07, init 0x00, MSB first, no reflection, no final
//               XOR) over the data byte and reports the result.
// Ports       : clk             - system clock, rising edge
//               reset           - synchronous active-high reset
//               rx_serial       - asynchronous UART line, idles high
//               rx_data_out     - last good-format data byte, held
//               rx_ready_out    - one-cycle pulse when a frame has been checked
//               crc_valid_out   - CRC match flag, updated with rx_ready_out
//               frame_error_out - one-cycle pulse on bad stop bit or gap timeout
// Revision    : 1.0 - initial release
// ============================================================================
module uart_crc_rx_checker #(
    parameter int CLKS_PER_BIT = 16,
    parameter int GAP_BITS     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_serial,
    output logic [7:0] rx_data_out,
    output logic       rx_ready_out,
    output logic       crc_valid_out,
    output logic       frame_error_out
);

    localparam int c_GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
    localparam int c_CNT_W     = $clog2(c_GAP_LIMIT);

    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    // GAP is entered the cycle after the stop sample with the counter at zero,
    // so the timeout decision falls in the cycle that puts the error pulse
    // exactly GAP_BITS*CLKS_PER_BIT cycles after the stop sample.
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(c_GAP_LIMIT - 2);
    localparam logic [7:0]         c_POLY      = 8'h07;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_GAP   = 3'd4;
    localparam logic [2:0] c_ST_CHECK = 3'd5;

    logic               r_sync1;
    logic               r_sync2;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic [7:0]         r_data_byte;
    logic [7:0]         r_crc_rx;
    logic [7:0]         r_crc;
    logic               r_byte_idx;
    logic [7:0]         r_data_out;
    logic               r_ready;
    logic               r_crc_ok;
    logic               r_frame_err;

    logic               w_line;
    logic               w_crc_bit;
    logic               w_crc_fb;
    logic [7:0]         w_crc_next;

    assign w_line     = r_sync2;
    // One CRC step per CHECK cycle, data byte consumed MSB first.
    assign w_crc_bit  = r_data_byte[3'd7 - r_bit_cnt];
    assign w_crc_fb   = r_crc[7] ^ w_crc_bit;
    assign w_crc_next = {r_crc[6:0], 1'b0} ^ (w_crc_fb ? c_POLY : 8'h00);

    assign rx_data_out     = r_data_out;
    assign rx_ready_out    = r_ready;
    assign crc_valid_out   = r_crc_ok;
    assign frame_error_out = r_frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= 8'h00;
            r_data_byte <= 8'h00;
            r_crc_rx    <= 8'h00;
            r_crc       <= 8'h00;
            r_byte_idx  <= 1'b0;
            r_data_out  <= 8'h00;
            r_ready     <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_ready     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_cnt <= '0;
                    if (!w_line) begin
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_line) begin
                            r_state <= c_ST_DATA;
                        end else begin
                            // Glitch: silently fall back to where we came from.
                            r_state <= r_byte_idx ? c_ST_GAP : c_ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_line, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_STOP: begin
                    if (r_cnt == c_BIT_LAST) begin
                        r_cnt <= '0;
                        if (!w_line) begin
                            r_frame_err <= 1'b1;
                            r_byte_idx  <= 1'b0;
                            r_state     <= c_ST_IDLE;
                        end else if (!r_byte_idx) begin
                            r_data_byte <= r_shift;
                            r_byte_idx  <= 1'b1;
                            r_state     <= c_ST_GAP;
                        end else begin
                            r_crc_rx  <= r_shift;
                            r_crc     <= 8'h00;
                            r_bit_cnt <= '0;
                            r_state   <= c_ST_CHECK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_GAP: begin
                    if (!w_line) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_START;
                    end else if (r_cnt == c_GAP_LAST) begin
                        r_cnt       <= '0;
                        r_frame_err <= 1'b1;
                        r_byte_idx  <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_CHECK: begin
                    if (r_bit_cnt == 3'd7) begin
                        // Last CRC step is folded into the compare.
                        r_data_out <= r_data_byte;
                        r_crc_ok   <= (w_crc_next == r_crc_rx);
                        r_ready    <= 1'b1;
                        r_byte_idx <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_state    <= c_ST_IDLE;
                    end else begin
                        r_crc     <= w_crc_next;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_crc_rx_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_crc_rx_checker
// Description : Self-checking bench for uart_crc_rx_checker. Drives 8N1
//               frames on rx_serial and compares pulses, data, CRC flag and
//               pulse timing against a polynomial-division CRC-8 model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_crc_rx_checker;

    localparam int CLKS     = 16;
    localparam int GAP_BITS = 20;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_data_out;
    logic       rx_ready_out;
    logic       crc_valid_out;
    logic       frame_error_out;

    uart_crc_rx_checker #(
        .CLKS_PER_BIT (CLKS),
        .GAP_BITS     (GAP_BITS)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .rx_serial       (rx_serial),
        .rx_data_out     (rx_data_out),
        .rx_ready_out    (rx_ready_out),
        .crc_valid_out   (crc_valid_out),
        .frame_error_out (frame_error_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         stamp;
        logic [7:0] data;
        logic       valid;
    } rdy_ev_t;

    int      total   = 0;
    int      bad     = 0;
    int      cyc     = 0;
    int      both_hi = 0;
    rdy_ev_t rdy_q[$];
    int      err_q[$];
    rdy_ev_t mon_ev;

    // Output observed after edge n belongs to cycle n+1.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #3;
        if (rx_ready_out === 1'b1) begin
            mon_ev.stamp = cyc + 1;
            mon_ev.data  = rx_data_out;
            mon_ev.valid = crc_valid_out;
            rdy_q.push_back(mon_ev);
        end
        if (frame_error_out === 1'b1) err_q.push_back(cyc + 1);
        if (rx_ready_out === 1'b1 && frame_error_out === 1'b1) both_hi = both_hi + 1;
    end

    // CRC-8 as the remainder of data*x^8 divided by x^8+x^2+x+1.
    function automatic logic [7:0] crc8_model(input logic [7:0] d);
        logic [15:0] r;
        r = {d, 8'h00};
        for (int i = 15; i >= 8; i--) begin
            if (r[i]) r = r ^ (16'h0107 << (i - 8));
        end
        return r[7:0];
    endfunction

    // Start bit driven just after edge c0: two synchroniser cycles, detection
    // in cycle c0+3, start sample half a bit later, stop sample nine bits on.
    function automatic int stop_cycle(input int c0);
        return c0 + 3 + CLKS / 2 + 9 * CLKS;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rx_serial = 1'b1;
        wait_cycles(n * CLKS);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int c0);
        c0 = cyc;
        rx_serial = 1'b0;
        wait_cycles(CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            wait_cycles(CLKS);
        end
        rx_serial = stop_bit;
        wait_cycles(CLKS);
        rx_serial = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [7:0] c, input int gap, output int s_crc);
        int c0;
        int c1;
        send_byte(d, 1'b1, c0);
        idle_bits(gap);
        send_byte(c, 1'b1, c1);
        s_crc = stop_cycle(c1);
    endtask

    task automatic clear_q();
        rdy_q.delete();
        err_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_serial = 1'b1;
        wait_cycles(3);
        total++; if (rx_data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rx_data_out); end
        total++; if (rx_ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", rx_ready_out); end
        total++; if (crc_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", crc_valid_out); end
        total++; if (frame_error_out !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", frame_error_out); end
        reset = 1'b0;
        wait_cycles(4);
    endtask

    task automatic test_basic();
        int s;
        logic [7:0] c;
        clear_q();
        c = 8'h5F;
        send_frame(8'hAA, c, 1, s);
        idle_bits(2);
        total++; if (rdy_q.size() != 1) begin bad++; $display("FAIL basic_count: got %0d want 1", rdy_q.size()); end
        if (rdy_q.size() >= 1) begin
            total++; if (rdy_q[0].stamp != s + 9) begin bad++; $display("FAIL basic_latency: got %0d want %0d", rdy_q[0].stamp, s + 9); end
            total++; if (rdy_q[0].data !== 8'hAA) begin bad++; $display("FAIL basic_data: got %h want aa", rdy_q[0].data); end
            total++; if (rdy_q[0].valid !== (c == crc8_model(8'hAA))) begin bad++; $display("FAIL basic_valid: got %b want %b", rdy_q[0].valid, (c == crc8_model(8'hAA))); end
        end
        total++; if (err_q.size() != 0) begin bad++; $display("FAIL basic_err: got %0d want 0", err_q.size()); end
    endtask

    task automatic test_back_to_back();
        int s1;
        int s2;
        clear_q();
        send_frame(8'hCC, 8'h6A, 1, s1);
        idle_bits(1);
        send_frame(8'hFF, 8'hF3, 1, s2);
        idle_bits(2);
        total++; if (rdy_q.size() != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", rdy_q.size()); end
        if (rdy_q.size() >= 2) begin
            total++; if (rdy_q[0].stamp != s1 + 9 || rdy_q[1].stamp != s2 + 9) begin bad++; $display("FAIL b2b_latency: got %0d/%0d want %0d/%0d", rdy_q[0].stamp, rdy_q[1].stamp, s1 + 9, s2 + 9); end
            total++; if (rdy_q[0].data !== 8'hCC || rdy_q[1].data !== 8'hFF) begin bad++; $display("FAIL b2b_data: got %h/%h want cc/ff", rdy_q[0].data, rdy_q[1].data); end
            total++; if (rdy_q[0].valid !== 1'b1 || rdy_q[1].valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b/%b want 1/1", rdy_q[0].valid, rdy_q[1].valid); end
        end
        total++; if (err_q.size() != 0) begin bad++; $display("FAIL b2b_err: got %0d want 0", err_q.size()); end
    endtask

    task automatic test_bad_crc();
        int s;
        logic [7:0] c;
        clear_q();
        c = 8'h5E;
        send_frame(8'hAA, c, 2, s);
        idle_bits(2);
        total++; if (rdy_q.size() != 1) begin bad++; $display("FAIL badcrc_count: got %0d want 1", rdy_q.size()); end
        if (rdy_q.size() >= 1) begin
            total++; if (rdy_q[0].data !== 8'hAA) begin bad++; $display("FAIL badcrc_data: got %h want aa", rdy_q[0].data); end
            total++; if (rdy_q[0].valid !== (c == crc8_model(8'hAA))) begin bad++; $display("FAIL badcrc_valid: got %b want %b", rdy_q[0].valid, (c == crc8_model(8'hAA))); end
        end
        clear_q();
        send_frame(8'h00, 8'h00, 1, s);
        idle_bits(2);
        total++; if (rdy_q.size() != 1) begin bad++; $display("FAIL zero_count: got %0d want 1", rdy_q.size()); end
        if (rdy_q.size() >= 1) begin
            total++; if (rdy_q[0].valid !== (8'h00 == crc8_model(8'h00))) begin bad++; $display("FAIL zero_valid: got %b want 1", rdy_q[0].valid); end
            total++; if (rdy_q[0].data !== 8'h00) begin bad++; $display("FAIL zero_data: got %h want 00", rdy_q[0].data); end
        end
        total++; if (err_q.size() != 0) begin bad++; $display("FAIL badcrc_err: got %0d want 0", err_q.size()); end
    endtask

    task automatic test_stop_error();
        int c0;
        int s;
        clear_q();
        send_byte(8'hA5, 1'b0, c0);
        idle_bits(3);
        total++; if (err_q.size() != 1) begin bad++; $display("FAIL stop_err_count: got %0d want 1", err_q.size()); end
        if (err_q.size() >= 1) begin
            total++; if (err_q[0] != stop_cycle(c0) + 1) begin bad++; $display("FAIL stop_err_time: got %0d want %0d", err_q[0], stop_cycle(c0) + 1); end
        end
        total++; if (rdy_q.size() != 0) begin bad++; $display("FAIL stop_err_ready: got %0d want 0", rdy_q.size()); end
        total++; if (rx_data_out !== 8'h00 || crc_valid_out !== 1'b1) begin bad++; $display("FAIL stop_err_hold: got %h/%b want 00/1", rx_data_out, crc_valid_out); end
        clear_q();
        send_frame(8'hAA, 8'h5F, 1, s);
        idle_bits(2);
        total++; if (rdy_q.size() != 1) begin bad++; $display("FAIL recover_count: got %0d want 1", rdy_q.size()); end
        if (rdy_q.size() >= 1) begin
            total++; if (rdy_q[0].data !== 8'hAA || rdy_q[0].valid !== 1'b1) begin bad++; $display("FAIL recover_frame: got %h/%b want aa/1", rdy_q[0].data, rdy_q[0].valid); end
        end
    endtask

    task automatic test_glitch_timeout();
        int c0;
        clear_q();
        rx_serial = 1'b0;
        wait_cycles(3);
        rx_serial = 1'b1;
        wait_cycles(40);
        total++; if (rdy_q.size() != 0 || err_q.size() != 0) begin bad++; $display("FAIL glitch_pulses: got %0d/%0d want 0/0", rdy_q.size(), err_q.size()); end
        total++; if (rx_data_out !== 8'hAA || crc_valid_out !== 1'b1) begin bad++; $display("FAIL glitch_hold: got %h/%b want aa/1", rx_data_out, crc_valid_out); end
        send_byte(8'h55, 1'b1, c0);
        idle_bits(GAP_BITS + 5);
        total++; if (err_q.size() != 1) begin bad++; $display("FAIL timeout_count: got %0d want 1", err_q.size()); end
        if (err_q.size() >= 1) begin
            total++; if (err_q[0] != stop_cycle(c0) + GAP_BITS * CLKS) begin bad++; $display("FAIL timeout_time: got %0d want %0d", err_q[0], stop_cycle(c0) + GAP_BITS * CLKS); end
        end
        total++; if (rdy_q.size() != 0) begin bad++; $display("FAIL timeout_ready: got %0d want 0", rdy_q.size()); end
        total++; if (rx_data_out !== 8'hAA) begin bad++; $display("FAIL timeout_data: got %h want aa", rx_data_out); end
    endtask

    task automatic test_reset_midframe();
        int c0;
        int s;
        clear_q();
        send_byte(8'h12, 1'b1, c0);
        idle_bits(1);
        // CRC byte 0xF8: start and bits 0..2 low, reset lands in the middle of bit 3.
        rx_serial = 1'b0;
        wait_cycles(CLKS * 4);
        rx_serial = 1'b1;
        wait_cycles(CLKS / 2);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        total++; if (rx_data_out !== 8'h00 || rx_ready_out !== 1'b0 || crc_valid_out !== 1'b0 || frame_error_out !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: got %h/%b/%b/%b want 00/0/0/0", rx_data_out, rx_ready_out, crc_valid_out, frame_error_out);
        end
        wait_cycles(CLKS / 2 - 1);
        idle_bits(5 + GAP_BITS + 5);
        total++; if (rdy_q.size() != 0 || err_q.size() != 0) begin bad++; $display("FAIL midreset_pulses: got %0d/%0d want 0/0", rdy_q.size(), err_q.size()); end
        clear_q();
        send_frame(8'hCC, 8'h6A, 1, s);
        idle_bits(2);
        total++; if (rdy_q.size() != 1) begin bad++; $display("FAIL midreset_next_count: got %0d want 1", rdy_q.size()); end
        if (rdy_q.size() >= 1) begin
            total++; if (rdy_q[0].data !== 8'hCC || rdy_q[0].valid !== 1'b1 || rdy_q[0].stamp != s + 9) begin
                bad++; $display("FAIL midreset_next_frame: got %h/%b@%0d want cc/1@%0d", rdy_q[0].data, rdy_q[0].valid, rdy_q[0].stamp, s + 9);
            end
        end
    endtask

    task automatic test_random();
        rdy_ev_t    exp_q[$];
        rdy_ev_t    e;
        logic [7:0] d;
        logic [7:0] c;
        logic [7:0] mask;
        int         s;
        int         n;
        clear_q();
        for (int k = 0; k < 12; k++) begin
            d    = 8'($urandom_range(0, 255));
            mask = 8'h01 << $urandom_range(0, 7);
            c    = crc8_model(d);
            if ($urandom_range(0, 2) == 0) c = c ^ mask;
            send_frame(d, c, int'($urandom_range(1, 6)), s);
            e.stamp = s + 9;
            e.data  = d;
            e.valid = (c == crc8_model(d));
            exp_q.push_back(e);
            idle_bits(int'($urandom_range(1, 4)));
        end
        idle_bits(2);
        total++; if (rdy_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count: got %0d want %0d", rdy_q.size(), exp_q.size()); end
        n = (rdy_q.size() < exp_q.size()) ? rdy_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            total++;
            if (rdy_q[k].stamp != exp_q[k].stamp || rdy_q[k].data !== exp_q[k].data || rdy_q[k].valid !== exp_q[k].valid) begin
                bad++;
                $display("FAIL rand_frame%0d: got %h/%b@%0d want %h/%b@%0d", k, rdy_q[k].data, rdy_q[k].valid, rdy_q[k].stamp,
                         exp_q[k].data, exp_q[k].valid, exp_q[k].stamp);
            end
        end
        total++; if (err_q.size() != 0) begin bad++; $display("FAIL rand_err: got %0d want 0", err_q.size()); end
    endtask

    task automatic test_exclusive();
        total++; if (both_hi != 0) begin bad++; $display("FAIL ready_err_overlap: got %0d want 0", both_hi); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_bad_crc();
        test_stop_error();
        test_glitch_timeout();
        test_reset_midframe();
        test_random();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
